banco_reg_pilha: RTL and testbench

//  Parametrised register bank for the single-cycle datapath. It replaces the fixed 64x32 bank.
//  Two combinational read ports feed the ALU operand muxes, each with write-through bypass.

---
 rtl/banco_reg_pilha.sv | 129 ++++++++++++
 tb/tb_banco_reg_pilha.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/banco_reg_pilha.sv
// banco_reg_pilha: parametrised register bank with two bypassed read ports,
// stack-pointer push/pop engine, JAL link write, NOP suppression and sticky
// stack overflow/underflow flags.
module banco_reg_pilha #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned SP_ADDR  = 29,
    parameter int unsigned RA_ADDR  = 31,
    parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_03FC,
    parameter logic [DATA_W-1:0] SP_MIN   = 32'h0000_0200,
    parameter int unsigned STEP     = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              reg_write,
    input  logic              nop,
    input  logic [1:0]        stack_op,
    input  logic              jal,
    input  logic [DATA_W-1:0] link_pc,
    output logic [DATA_W-1:0] dado_a,
    output logic [DATA_W-1:0] dado_b,
    output logic [DATA_W-1:0] sp_out,
    output logic              stack_ovf,
    output logic              stack_unf
);

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_RSVD = 2'b11
    } stack_op_e;

    localparam int unsigned       LP_DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LP_SP       = ADDR_W'(SP_ADDR);
    localparam logic [ADDR_W-1:0] LP_RA       = ADDR_W'(RA_ADDR);
    localparam logic [DATA_W-1:0] LP_STEP     = DATA_W'(STEP);
    localparam logic [DATA_W-1:0] LP_PUSH_MIN = SP_MIN + LP_STEP;
    localparam logic [DATA_W-1:0] LP_POP_MAX  = SP_RESET - LP_STEP;

    logic [DATA_W-1:0] r_regs [LP_DEPTH];
    logic              r_ovf;
    logic              r_unf;

    logic [DATA_W-1:0] w_sp;
    logic [DATA_W-1:0] w_sp_next;
    logic              w_push;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_pop_ok;
    logic              w_sp_we;
    logic              w_ra_we;
    logic              w_rd_we;

    // Stack engine legality and write arbitration (stack > jal > reg_write);
    // a failed stack op is not a write, so it blocks nothing.
    always_comb begin
        w_sp      = r_regs[LP_SP];
        w_push    = (stack_op == OP_PUSH);
        w_pop     = (stack_op == OP_POP);
        w_push_ok = (w_sp >= LP_PUSH_MIN);
        w_pop_ok  = (w_sp <= LP_POP_MAX);
        w_sp_next = w_push ? (w_sp - LP_STEP) : (w_sp + LP_STEP);
        w_sp_we   = !nop && (LP_SP != '0) &&
                    ((w_push && w_push_ok) || (w_pop && w_pop_ok));
        w_ra_we   = !nop && jal && (LP_RA != '0) &&
                    !(w_sp_we && (LP_RA == LP_SP));
        w_rd_we   = !nop && reg_write && (rd_addr != '0) &&
                    !(w_sp_we && (rd_addr == LP_SP)) &&
                    !(w_ra_we && (rd_addr == LP_RA));
    end

    // Read port A with write-through bypass of the winning write.
    always_comb begin
        dado_a = r_regs[rs_addr];
        if (rs_addr == '0)
            dado_a = '0;
        else if (w_sp_we && (rs_addr == LP_SP))
            dado_a = w_sp_next;
        else if (w_ra_we && (rs_addr == LP_RA))
            dado_a = link_pc;
        else if (w_rd_we && (rs_addr == rd_addr))
            dado_a = wr_data;
    end

    // Read port B with write-through bypass of the winning write.
    always_comb begin
        dado_b = r_regs[rt_addr];
        if (rt_addr == '0)
            dado_b = '0;
        else if (w_sp_we && (rt_addr == LP_SP))
            dado_b = w_sp_next;
        else if (w_ra_we && (rt_addr == LP_RA))
            dado_b = link_pc;
        else if (w_rd_we && (rt_addr == rd_addr))
            dado_b = wr_data;
    end

    // Register and flag update; reset dominates, nop freezes all state.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < LP_DEPTH; i++)
                r_regs[i] <= '0;
            r_regs[LP_SP] <= SP_RESET;
            r_ovf         <= 1'b0;
            r_unf         <= 1'b0;
        end else if (!nop) begin
            if (w_rd_we)
                r_regs[rd_addr] <= wr_data;
            if (w_ra_we)
                r_regs[LP_RA] <= link_pc;
            if (w_sp_we)
                r_regs[LP_SP] <= w_sp_next;
            if (w_push && !w_push_ok)
                r_ovf <= 1'b1;
            if (w_pop && !w_pop_ok)
                r_unf <= 1'b1;
        end
    end

    assign sp_out    = r_regs[LP_SP];
    assign stack_ovf = r_ovf;
    assign stack_unf = r_unf;

endmodule

// File: tb/tb_banco_reg_pilha.sv
// Directed testbench for banco_reg_pilha with hand-computed expectations.
module tb_banco_reg_pilha;

    logic        clock;
    logic        reset;
    logic [5:0]  rs_addr;
    logic [5:0]  rt_addr;
    logic [5:0]  rd_addr;
    logic [31:0] wr_data;
    logic        reg_write;
    logic        nop;
    logic [1:0]  stack_op;
    logic        jal;
    logic [31:0] link_pc;
    logic [31:0] dado_a;
    logic [31:0] dado_b;
    logic [31:0] sp_out;
    logic        stack_ovf;
    logic        stack_unf;

    int n_checks = 0;
    int n_fail   = 0;

    banco_reg_pilha #(
        .DATA_W   (32),
        .ADDR_W   (6),
        .SP_ADDR  (29),
        .RA_ADDR  (31),
        .SP_RESET (32'h0000_03FC),
        .SP_MIN   (32'h0000_0200),
        .STEP     (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rd_addr   (rd_addr),
        .wr_data   (wr_data),
        .reg_write (reg_write),
        .nop       (nop),
        .stack_op  (stack_op),
        .jal       (jal),
        .link_pc   (link_pc),
        .dado_a    (dado_a),
        .dado_b    (dado_b),
        .sp_out    (sp_out),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then move 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        reg_write = 1'b0;
        nop       = 1'b0;
        stack_op  = 2'b00;
        jal       = 1'b0;
        rd_addr   = '0;
        wr_data   = '0;
        link_pc   = '0;
    endtask

    initial begin
        idle();
        reset   = 1'b1;
        rs_addr = 6'd29;
        rt_addr = 6'd5;
        tick();
        reset = 1'b0;
        #1;

        // 1: reset state
        chk("rst_dado_a_sp", dado_a, 32'h3FC);
        chk("rst_sp_out", sp_out, 32'h3FC);
        chk("rst_dado_b_r5", dado_b, 32'h0);
        chk("rst_ovf", {31'b0, stack_ovf}, 32'h0);
        chk("rst_unf", {31'b0, stack_unf}, 32'h0);

        // 2: basic writes and R0
        reg_write = 1'b1; rd_addr = 6'd3; wr_data = 32'd10;
        tick();
        rd_addr = 6'd4; wr_data = 32'd20;
        tick();
        idle();
        rs_addr = 6'd3; rt_addr = 6'd4;
        #1;
        chk("r3", dado_a, 32'd10);
        chk("r4", dado_b, 32'd20);
        reg_write = 1'b1; rd_addr = 6'd0; wr_data = 32'd7; rs_addr = 6'd0;
        #1;
        chk("r0_bypass", dado_a, 32'd0);
        tick();
        idle();
        #1;
        chk("r0_after", dado_a, 32'd0);

        // 3: bypass then stored value
        reg_write = 1'b1; rd_addr = 6'd4; wr_data = 32'd99; rs_addr = 6'd4; rt_addr = 6'd3;
        #1;
        chk("byp_r4_a", dado_a, 32'd99);
        chk("byp_r3_b", dado_b, 32'd10);
        tick();
        idle();
        #1;
        chk("r4_stored", dado_a, 32'd99);

        // 4: push x2, pop x3 with underflow
        rs_addr = 6'd29;
        stack_op = 2'b01;
        #1;
        chk("push_byp", dado_a, 32'h3F8);
        chk("push_sp_nobyp", sp_out, 32'h3FC);
        tick();
        tick();
        stack_op = 2'b00;
        #1;
        chk("push2_sp", sp_out, 32'h3F4);
        stack_op = 2'b10;
        tick();
        tick();
        #1;
        chk("pop2_sp", sp_out, 32'h3FC);
        chk("pop2_unf", {31'b0, stack_unf}, 32'h0);
        chk("pop3_byp", dado_a, 32'h3FC);
        tick();
        stack_op = 2'b00;
        #1;
        chk("pop3_sp", sp_out, 32'h3FC);
        chk("pop3_unf", {31'b0, stack_unf}, 32'h1);
        tick();
        tick();
        chk("unf_sticky", {31'b0, stack_unf}, 32'h1);

        // priority: push beats reg_write to SP
        stack_op = 2'b01; reg_write = 1'b1; rd_addr = 6'd29; wr_data = 32'h123;
        #1;
        chk("prio_sp_byp", dado_a, 32'h3F8);
        tick();
        idle();
        #1;
        chk("prio_sp", sp_out, 32'h3F8);
        stack_op = 2'b10;
        tick();
        idle();

        // 5: jal beats reg_write on RA
        jal = 1'b1; link_pc = 32'h40; reg_write = 1'b1; rd_addr = 6'd31; wr_data = 32'd5;
        rs_addr = 6'd31;
        #1;
        chk("jal_byp", dado_a, 32'h40);
        tick();
        idle();
        #1;
        chk("jal_r31", dado_a, 32'h40);
        nop = 1'b1; jal = 1'b1; link_pc = 32'h80; reg_write = 1'b1; rd_addr = 6'd31;
        wr_data = 32'd6; stack_op = 2'b01; rt_addr = 6'd29;
        #1;
        chk("nop_byp_a", dado_a, 32'h40);
        chk("nop_byp_b", dado_b, 32'h3FC);
        tick();
        idle();
        #1;
        chk("nop_r31", dado_a, 32'h40);
        chk("nop_sp", sp_out, 32'h3FC);

        // 6: overflow burst
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stack_op = 2'b01;
        repeat (126) tick();
        chk("burst126_sp", sp_out, 32'h204);
        chk("burst126_ovf", {31'b0, stack_ovf}, 32'h0);
        tick();
        chk("burst127_sp", sp_out, 32'h200);
        chk("burst127_ovf", {31'b0, stack_ovf}, 32'h0);
        reg_write = 1'b1; rd_addr = 6'd7; wr_data = 32'h77;
        tick();
        reg_write = 1'b0;
        rs_addr = 6'd7;
        #1;
        chk("burst128_sp", sp_out, 32'h200);
        chk("burst128_ovf", {31'b0, stack_ovf}, 32'h1);
        chk("failpush_r7", dado_a, 32'h77);

        // reset mid-burst with a push still pending
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        #1;
        chk("midrst_sp", sp_out, 32'h3FC);
        chk("midrst_ovf", {31'b0, stack_ovf}, 32'h0);
        chk("midrst_unf", {31'b0, stack_unf}, 32'h0);
        chk("midrst_r7", dado_a, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
